// File: rtl/eject_unit.sv
// Ejection stage of the deflection router: pulls at most one locally addressed
// flit per cycle into a small FIFO and registers every other flit onward.
module eject_unit #(
  parameter int NODE_ROW = 4,
  parameter int NODE_COL = 4,
  parameter int DW       = 16,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 in_valid,
  input  logic [23:0]                in_addr,
  input  logic [4*DW-1:0]            in_data,
  output logic [3:0]                 out_valid,
  output logic [23:0]                out_addr,
  output logic [4*DW-1:0]            out_data,
  output logic [3:0]                 eject_dir,
  output logic                       local_valid,
  output logic [5:0]                 local_addr,
  output logic [DW-1:0]              local_data,
  input  logic                       local_ready,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [3:0]    match;
  logic          grant_valid;
  logic [1:0]    grant_idx;
  logic [1:0]    rr_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic [5:0]    mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      match[k] = in_valid[k]
              && (in_addr[6*k+3 +: 3] == 3'(NODE_ROW))
              && (in_addr[6*k   +: 3] == 3'(NODE_COL));
    end
  end

  // Occupancy is judged before any same-cycle pop, so a full FIFO never grants.
  always_comb begin
    logic [1:0] idx;
    idx         = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (count < CW'(DEPTH)) begin
      for (int i = 0; i < 4; i++) begin
        idx = rr_ptr + 2'(i);
        if (!grant_valid && match[idx]) begin
          grant_valid = 1'b1;
          grant_idx   = idx;
        end
      end
    end
  end

  assign push        = grant_valid;
  assign pop         = local_valid && local_ready;
  assign local_valid = (count != '0);
  assign local_addr  = mem_addr[rd_ptr];
  assign local_data  = mem_data[rd_ptr];
  assign fifo_count  = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_addr  <= '0;
      out_data  <= '0;
      eject_dir <= '0;
      rr_ptr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (in_valid[k] && !(grant_valid && (grant_idx == 2'(k)))) begin
          out_valid[k]          <= 1'b1;
          out_addr[6*k +: 6]    <= in_addr[6*k +: 6];
          out_data[DW*k +: DW]  <= in_data[DW*k +: DW];
        end else begin
          out_valid[k]          <= 1'b0;
          out_addr[6*k +: 6]    <= '0;
          out_data[DW*k +: DW]  <= '0;
        end
      end

      eject_dir <= grant_valid ? (4'(1) << grant_idx) : 4'b0000;
      if (grant_valid) begin
        rr_ptr <= grant_idx + 2'd1;
      end

      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) begin
        mem_addr[wr_ptr] <= in_addr[6*grant_idx +: 6];
        mem_data[wr_ptr] <= in_data[DW*grant_idx +: DW];
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_eject_unit.sv
// Self-checking bench for eject_unit: directed vector table plus randomized
// traffic, both checked against a queue-based reference model.
module tb_eject_unit;

  localparam int DEPTH = 4;
  localparam logic [5:0] MY_ADDR = 6'h24;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [23:0] in_addr;
  logic [63:0] in_data;
  logic [3:0]  out_valid;
  logic [23:0] out_addr;
  logic [63:0] out_data;
  logic [3:0]  eject_dir;
  logic        local_valid;
  logic [5:0]  local_addr;
  logic [15:0] local_data;
  logic        local_ready;
  logic [2:0]  fifo_count;

  int compared   = 0;
  int mismatched = 0;

  logic [21:0] mQ[$];
  int          mRr;
  logic [3:0]  expValid;
  logic [23:0] expAddr;
  logic [63:0] expData;
  logic [3:0]  expEject;

  typedef struct packed {
    logic        rst;
    logic [3:0]  valid;
    logic [23:0] addr;
    logic [63:0] data;
    logic        ready;
    logic [3:0]  expOutValid;
    logic [3:0]  expEject;
    logic [2:0]  expCount;
    logic [15:0] expHead;
  } vec_t;

  vec_t vecs[24];

  eject_unit #(.NODE_ROW(4), .NODE_COL(4), .DW(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data),
    .eject_dir(eject_dir),
    .local_valid(local_valid), .local_addr(local_addr), .local_data(local_data),
    .local_ready(local_ready), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: eject the first local flit scanning from the round-robin start, then pop-before-push on a queue.
  task automatic modelStep();
    int g;
    int k;
    if (rst) begin
      mQ.delete();
      mRr = 0;
      expValid = '0; expAddr = '0; expData = '0; expEject = '0;
    end else begin
      g = -1;
      if (mQ.size() < DEPTH) begin
        for (int i = 0; i < 4; i++) begin
          k = (mRr + i) % 4;
          if (g < 0 && in_valid[k] && in_addr[6*k +: 6] == MY_ADDR) g = k;
        end
      end
      for (int p = 0; p < 4; p++) begin
        if (in_valid[p] && p != g) begin
          expValid[p] = 1'b1;
          expAddr[6*p +: 6]   = in_addr[6*p +: 6];
          expData[16*p +: 16] = in_data[16*p +: 16];
        end else begin
          expValid[p] = 1'b0;
          expAddr[6*p +: 6]   = '0;
          expData[16*p +: 16] = '0;
        end
      end
      expEject = (g >= 0) ? 4'(1 << g) : 4'b0000;
      if (mQ.size() > 0 && local_ready) void'(mQ.pop_front());
      if (g >= 0) begin
        mQ.push_back({in_addr[6*g +: 6], in_data[16*g +: 16]});
        mRr = (g + 1) % 4;
      end
    end
  endtask

  task automatic checkOutput();
    check("out_valid", 64'(out_valid), 64'(expValid));
    check("out_addr", 64'(out_addr), 64'(expAddr));
    check("out_data", out_data, expData);
    check("eject_dir", 64'(eject_dir), 64'(expEject));
    check("fifo_count", 64'(fifo_count), 64'(mQ.size()));
    check("local_valid", 64'(local_valid), 64'(mQ.size() != 0));
    if (mQ.size() != 0) begin
      check("local_addr", 64'(local_addr), 64'(mQ[0][21:16]));
      check("local_data", 64'(local_data), 64'(mQ[0][15:0]));
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [23:0] a,
                               input logic [63:0] d, input logic rdy);
    rst = r; in_valid = v; in_addr = a; in_data = d; local_ready = rdy;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [23:0] ra;
    logic [63:0] rd;
    rst = 1'b1; in_valid = '0; in_addr = '0; in_data = '0; local_ready = 1'b0;
    mRr = 0;
    expValid = '0; expAddr = '0; expData = '0; expEject = '0;

    vecs[0]  = '{1'b1, 4'b0000, 24'h0, 64'h0, 1'b0, 4'b0000, 4'b0000, 3'd0, 16'h0};
    vecs[1]  = '{1'b0, 4'b0100, 24'h024000, 64'h0000_BEEF_0000_0000, 1'b0, 4'b0000, 4'b0100, 3'd1, 16'hBEEF};
    vecs[2]  = '{1'b1, 4'b0000, 24'h0, 64'h0, 1'b0, 4'b0000, 4'b0000, 3'd0, 16'h0};
    vecs[3]  = '{1'b0, 4'b1111, 24'h492492, 64'h0004_0003_0002_0001, 1'b0, 4'b1111, 4'b0000, 3'd0, 16'h0};
    vecs[4]  = '{1'b0, 4'b1111, 24'h924924, 64'h1111_2222_3333_4444, 1'b1, 4'b1110, 4'b0001, 3'd1, 16'h4444};
    vecs[5]  = '{1'b0, 4'b1111, 24'h924924, 64'h1111_2222_3333_4444, 1'b1, 4'b1101, 4'b0010, 3'd1, 16'h3333};
    vecs[6]  = '{1'b0, 4'b1111, 24'h924924, 64'h1111_2222_3333_4444, 1'b1, 4'b1011, 4'b0100, 3'd1, 16'h2222};
    vecs[7]  = '{1'b0, 4'b1111, 24'h924924, 64'h1111_2222_3333_4444, 1'b1, 4'b0111, 4'b1000, 3'd1, 16'h1111};
    vecs[8]  = '{1'b1, 4'b0000, 24'h0, 64'h0, 1'b0, 4'b0000, 4'b0000, 3'd0, 16'h0};
    vecs[9]  = '{1'b0, 4'b0001, 24'h000024, 64'hA001, 1'b0, 4'b0000, 4'b0001, 3'd1, 16'hA001};
    vecs[10] = '{1'b0, 4'b0001, 24'h000024, 64'hA002, 1'b0, 4'b0000, 4'b0001, 3'd2, 16'hA001};
    vecs[11] = '{1'b0, 4'b0001, 24'h000024, 64'hA003, 1'b0, 4'b0000, 4'b0001, 3'd3, 16'hA001};
    vecs[12] = '{1'b0, 4'b0001, 24'h000024, 64'hA004, 1'b0, 4'b0000, 4'b0001, 3'd4, 16'hA001};
    vecs[13] = '{1'b0, 4'b0001, 24'h000024, 64'hA005, 1'b0, 4'b0001, 4'b0000, 3'd4, 16'hA001};
    vecs[14] = '{1'b0, 4'b0001, 24'h000024, 64'hA005, 1'b1, 4'b0001, 4'b0000, 3'd3, 16'hA002};
    vecs[15] = '{1'b0, 4'b0000, 24'h0, 64'h0, 1'b1, 4'b0000, 4'b0000, 3'd2, 16'hA003};
    vecs[16] = '{1'b0, 4'b0001, 24'h000024, 64'hA006, 1'b1, 4'b0000, 4'b0001, 3'd2, 16'hA004};
    vecs[17] = '{1'b0, 4'b0001, 24'h000024, 64'hA007, 1'b1, 4'b0000, 4'b0001, 3'd2, 16'hA006};
    vecs[18] = '{1'b0, 4'b0001, 24'h000024, 64'hA008, 1'b1, 4'b0000, 4'b0001, 3'd2, 16'hA007};
    vecs[19] = '{1'b0, 4'b0001, 24'h000024, 64'hA009, 1'b1, 4'b0000, 4'b0001, 3'd2, 16'hA008};
    vecs[20] = '{1'b0, 4'b0001, 24'h000024, 64'hA00A, 1'b0, 4'b0000, 4'b0001, 3'd3, 16'hA008};
    vecs[21] = '{1'b1, 4'b0001, 24'h000024, 64'hA00B, 1'b1, 4'b0000, 4'b0000, 3'd0, 16'h0};
    vecs[22] = '{1'b0, 4'b0000, 24'h0, 64'h0, 1'b0, 4'b0000, 4'b0000, 3'd0, 16'h0};
    vecs[23] = '{1'b0, 4'b1111, 24'h924924, 64'h1111_2222_3333_4444, 1'b0, 4'b1110, 4'b0001, 3'd1, 16'h4444};

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].addr, vecs[i].data, vecs[i].ready);
      check($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].expOutValid));
      check($sformatf("tbl%0d_eject_dir", i), 64'(eject_dir), 64'(vecs[i].expEject));
      check($sformatf("tbl%0d_fifo_count", i), 64'(fifo_count), 64'(vecs[i].expCount));
      check($sformatf("tbl%0d_local_valid", i), 64'(local_valid), 64'(vecs[i].expCount != 0));
      if (vecs[i].expCount != 0)
        check($sformatf("tbl%0d_head", i), 64'(local_data), 64'(vecs[i].expHead));
    end

    // Random traffic biased toward local addresses so the FIFO fills and drains.
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 4; p++)
        ra[6*p +: 6] = ($urandom_range(1) == 1) ? MY_ADDR : 6'($urandom);
      rd = {$urandom, $urandom};
      applyStimulus(($urandom_range(39) == 0), 4'($urandom), ra, rd,
                    ($urandom_range(2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
